// File: rtl/shift4_deser_if.sv
// rtl/shift4_deser_if.sv - handshake and serial-link bundle for the shift4_deser receiver
// Ports (slave view, as seen by shift4_deser):
//   start, ena, sin, out_ready   in   frame start, bit valid, serial data (LSB first), consumer ready
//   q[size-1:0]                  out  assembled word
//   out_valid, busy              out  word pending, frame in progress
//   overrun, par_err             out  sticky drop flag, parity mismatch for the word in q
interface shift4_deser_if #(
  parameter int size = 4
);
  logic            start;
  logic            ena;
  logic            sin;
  logic            out_ready;
  logic [size-1:0] q;
  logic            out_valid;
  logic            busy;
  logic            overrun;
  logic            par_err;

  modport master (
    output start, ena, sin, out_ready,
    input  q, out_valid, busy, overrun, par_err
  );

  modport slave (
    input  start, ena, sin, out_ready,
    output q, out_valid, busy, overrun, par_err
  );
endinterface

// File: rtl/shift4_deser.sv
// rtl/shift4_deser.sv - serial-to-parallel receiver for an LSB-first Shift4 stream
// Optional feature macro: SHIFT4_DESER_PARITY_EN (appends an even-parity bit per frame)
// Ports:
//   clk     in  rising-edge clock
//   areset  in  asynchronous active-high reset
//   bus     slave modport of shift4_deser_if (start/ena/sin/out_ready in,
//           q/out_valid/busy/overrun/par_err out)
module shift4_deser #(
  parameter int size = 4
) (
  input  logic           clk,
  input  logic           areset,
  shift4_deser_if.slave  bus
);

  localparam int CNT_W = (size > 1) ? $clog2(size) : 1;

`ifdef SHIFT4_DESER_PARITY_EN
  // Whole data word is held in the shift register until the parity bit arrives.
  localparam int SREG_W = size;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  // The final data bit is taken straight from sin, so only size-1 bits are stored.
  localparam int SREG_W = size - 1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [SREG_W-1:0] sreg;
  logic [size-1:0]   q_r;
  logic              valid_r;
  logic              overrun_r;

  logic              last_bit;
  logic              offer;
  logic [size-1:0]   offer_word;

  assign last_bit = (count == CNT_W'(size - 1));

`ifdef SHIFT4_DESER_PARITY_EN
  logic perr_r;
  logic offer_perr;

  // Word is offered on the parity-bit edge; start always wins over ena.
  always_comb begin
    offer      = (state == PAR) && !bus.start && bus.ena;
    offer_word = sreg;
    offer_perr = ^{bus.sin, sreg};
  end

  assign bus.par_err = perr_r;
`else
  // Word is offered on the last data-bit edge with the incoming bit as MSB.
  always_comb begin
    offer      = (state == SHIFT) && !bus.start && bus.ena && last_bit;
    offer_word = {bus.sin, sreg};
  end

  assign bus.par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      count     <= '0;
      sreg      <= '0;
      q_r       <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
`ifdef SHIFT4_DESER_PARITY_EN
      perr_r    <= 1'b0;
`endif
    end else begin
      // Frame sequencing
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= SHIFT;
            count <= '0;
            sreg  <= '0;
          end
        end
        SHIFT: begin
          if (bus.start) begin
            // Restart discards any bit presented alongside start.
            count <= '0;
            sreg  <= '0;
          end else if (bus.ena) begin
            // Right shift: newest bit enters at the MSB, so LSB-first data lands in place.
            sreg <= SREG_W'({bus.sin, sreg} >> 1);
            if (last_bit) begin
              count <= '0;
`ifdef SHIFT4_DESER_PARITY_EN
              state <= PAR;
`else
              state <= IDLE;
`endif
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
`ifdef SHIFT4_DESER_PARITY_EN
        PAR: begin
          if (bus.start) begin
            state <= SHIFT;
            count <= '0;
            sreg  <= '0;
          end else if (bus.ena) begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase

      // Output register: a pending word accepted on the same edge makes room for the new one.
      if (offer) begin
        if (!valid_r || bus.out_ready) begin
          q_r     <= offer_word;
          valid_r <= 1'b1;
`ifdef SHIFT4_DESER_PARITY_EN
          perr_r  <= offer_perr;
`endif
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && bus.out_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.q         = q_r;
  assign bus.out_valid = valid_r;
  assign bus.overrun   = overrun_r;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_shift4_deser.sv
// tb/tb_shift4_deser.sv - table-driven, scoreboarded bench for shift4_deser
module tb_shift4_deser;

  logic clk;
  logic areset;

  shift4_deser_if #(.size(4)) bus ();

  shift4_deser #(.size(4)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {par_err, q} expected for each word that should reach the output register
  logic [4:0] sb[$];

  typedef struct {
    logic [0:3] bits;   // send order: bits[0] goes first
    int         maxgap; // 0 = back-to-back, else 1..maxgap idle cycles between bits
    logic [3:0] q_exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends start, four data bits (and the parity bit when that feature is built in).
  task automatic send_word(input logic [0:3] bits, input int maxgap, input logic rdy_last,
                           input logic bad_par, input logic push, input logic [3:0] q_exp);
    logic ov_before;
    logic perr_exp;
    logic is_final;
    int   g;
    bus.ena       = 1'b0;
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1'b1);
    ov_before = bus.out_valid;
`ifdef SHIFT4_DESER_PARITY_EN
    perr_exp = bad_par;
`else
    perr_exp = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && maxgap > 0) begin
        g = $urandom_range(1, maxgap);
        bus.ena = 1'b0;
        repeat (g) tick();
        check("gap_no_valid", bus.out_valid, ov_before);
      end
      bus.ena = 1'b1;
      bus.sin = bits[i];
`ifdef SHIFT4_DESER_PARITY_EN
      is_final = 1'b0;
`else
      is_final = (i == 3);
`endif
      if (is_final) begin
        bus.out_ready = rdy_last;
        if (push) sb.push_back({perr_exp, q_exp});
      end
      tick();
      if (!is_final) check("no_early_valid", bus.out_valid, ov_before);
    end
`ifdef SHIFT4_DESER_PARITY_EN
    bus.ena       = 1'b1;
    bus.sin       = (^bits) ^ bad_par;
    bus.out_ready = rdy_last;
    if (push) sb.push_back({perr_exp, q_exp});
    tick();
`endif
    bus.ena       = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_out(input string name);
    logic [4:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb_empty: got 0 entries expected 1", name);
    end else begin
      e = sb.pop_front();
      check({name, "_valid"}, bus.out_valid, 1'b1);
      check({name, "_q"}, bus.q, e[3:0]);
      check({name, "_par_err"}, bus.par_err, e[4]);
      check({name, "_busy"}, bus.busy, 1'b0);
    end
  endtask

  task automatic consume(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_valid_clr"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{4'b1011, 0, 4'b1101};
    vecs[1] = '{4'b1011, 3, 4'b1101};
    vecs[2] = '{4'b0000, 0, 4'b0000};
    vecs[3] = '{4'b1111, 2, 4'b1111};
    vecs[4] = '{4'b0100, 1, 4'b0010};
    vecs[5] = '{4'b0001, 0, 4'b1000};
    vecs[6] = '{4'b1100, 3, 4'b0011};

    bus.start = 1'b0;
    bus.ena = 1'b0;
    bus.sin = 1'b0;
    bus.out_ready = 1'b0;
    areset = 1'b1;
    tick();
    tick();
    check("rst_q", bus.q, 4'h0);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    check("rst_par_err", bus.par_err, 1'b0);
    areset = 1'b0;
    tick();
    check("idle_after_rst", bus.busy, 1'b0);

    // Table of frames, back-to-back and with idle gaps
    for (int v = 0; v < 7; v++) begin
      send_word(vecs[v].bits, vecs[v].maxgap, 1'b0, 1'b0, 1'b1, vecs[v].q_exp);
      expect_out("vec");
      consume("vec");
    end

    // Handshake and reload on the same edge: no overrun
    send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1, 4'b1101);
    expect_out("reload_a");
    send_word(4'b0110, 1, 1'b1, 1'b0, 1'b1, 4'b0110);
    expect_out("reload_b");
    check("reload_no_overrun", bus.overrun, 1'b0);
    consume("reload");

    // Restart mid-frame; the bit alongside the second start is discarded
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ena = 1'b1;
    bus.sin = 1'b1;
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_busy", bus.busy, 1'b1);
    check("restart_no_valid", bus.out_valid, 1'b0);
    bus.sin = 1'b0;
    tick();
    tick();
    tick();
    bus.sin = 1'b1;
`ifdef SHIFT4_DESER_PARITY_EN
    tick();
    bus.sin = 1'b1;
`endif
    sb.push_back({1'b0, 4'b1000});
    tick();
    bus.ena = 1'b0;
    expect_out("restart");
    consume("restart");

`ifdef SHIFT4_DESER_PARITY_EN
    send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1, 4'b1101);
    expect_out("par_good");
    consume("par_good");
    send_word(4'b1011, 2, 1'b0, 1'b1, 1'b1, 4'b1101);
    expect_out("par_bad");
    consume("par_bad");
`else
    // A fifth enabled bit after the frame lands in IDLE and is ignored
    send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1, 4'b1101);
    bus.ena = 1'b1;
    bus.sin = 1'b0;
    tick();
    bus.ena = 1'b0;
    check("extra_bit_idle", bus.busy, 1'b0);
    check("extra_bit_overrun", bus.overrun, 1'b0);
    expect_out("extra_bit");
    consume("extra_bit");
`endif

    // Overrun: second word dropped while the first is held; start does not disturb q
    send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1, 4'b1101);
    expect_out("hold");
    send_word(4'b0100, 0, 1'b0, 1'b0, 1'b0, 4'b0010);
    check("drop_q_held", bus.q, 4'b1101);
    check("drop_valid", bus.out_valid, 1'b1);
    check("drop_overrun", bus.overrun, 1'b1);
    consume("drop");
    check("overrun_sticky", bus.overrun, 1'b1);

    // Leave a word pending, then reset asynchronously in the middle of a frame
    send_word(4'b1111, 0, 1'b0, 1'b0, 1'b1, 4'b1111);
    expect_out("pre_rst");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ena = 1'b1;
    bus.sin = 1'b1;
    tick();
    tick();
    bus.ena = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check("async_rst_q", bus.q, 4'h0);
    check("async_rst_valid", bus.out_valid, 1'b0);
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_overrun", bus.overrun, 1'b0);
    check("async_rst_par_err", bus.par_err, 1'b0);
    tick();
    areset = 1'b0;
    bus.ena = 1'b1;
    bus.sin = 1'b1;
    repeat (6) tick();
    bus.ena = 1'b0;
    check("post_rst_idle", bus.busy, 1'b0);
    check("post_rst_valid", bus.out_valid, 1'b0);
    check("post_rst_q", bus.q, 4'h0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
